tagger_sequencer: RTL and testbench

Run controller for the event tagger: replaces the host's hand-toggling of the timer control bits with a hardware sequence (counter reset, arm, timed capture window, pipeline drain). Sits between the 8-bit register bus and the tagger's `capture_operate`/`counter_operate`/`reset_counter` inputs. It also counts records emitted and records lost to a full downstream FIFO.

---
 rtl/tagger_sequencer.sv | 134 +++++++++++++
 tb/tb_tagger_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/tagger_sequencer.sv
// Run controller for the event tagger: sequences counter reset, arm, timed capture and drain,
// and counts accepted and lost records during the capture/drain window.
module tagger_sequencer #(
    parameter logic [7:0] ADDR         = 8'h08,
    parameter int         RESET_CYCLES = 4,
    parameter int         DRAIN_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  reg_addr,
    input  logic [7:0]  reg_data,
    input  logic        reg_wr,
    input  logic        data_rdy,
    input  logic        fifo_full,
    output logic        capture_operate,
    output logic        counter_operate,
    output logic        reset_counter,
    output logic        busy,
    output logic        done,
    output logic [31:0] record_count,
    output logic [15:0] lost_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_ARM,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [7:0]  A_CMD      = ADDR;
    localparam logic [7:0]  A_D0       = ADDR + 8'd1;
    localparam logic [7:0]  A_D1       = ADDR + 8'd2;
    localparam logic [7:0]  A_D2       = ADDR + 8'd3;
    localparam logic [7:0]  A_D3       = ADDR + 8'd4;
    localparam logic [15:0] RESET_LAST = 16'(RESET_CYCLES - 1);
    localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_CYCLES - 1);

    state_t      state, next_state;
    logic        start_p0, stop_p0, clear_p0;
    logic [31:0] duration;
    logic [31:0] run_timer;
    logic [15:0] phase_cnt;
    logic        idle_or_done;
    logic        clr_cnt;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Bus write stage: command pulses and duration bytes are registered here
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            start_p0 <= 1'b0;
            stop_p0  <= 1'b0;
            clear_p0 <= 1'b0;
            duration <= 32'd0;
        end else begin
            start_p0 <= reg_wr && (reg_addr == A_CMD) && reg_data[0];
            stop_p0  <= reg_wr && (reg_addr == A_CMD) && reg_data[1];
            clear_p0 <= reg_wr && (reg_addr == A_CMD) && reg_data[2];
            if (reg_wr && reg_addr == A_D0) duration[7:0]   <= reg_data;
            if (reg_wr && reg_addr == A_D1) duration[15:8]  <= reg_data;
            if (reg_wr && reg_addr == A_D2) duration[23:16] <= reg_data;
            if (reg_wr && reg_addr == A_D3) duration[31:24] <= reg_data;
        end
    end

    // Sequencer stage
    always_ff @(posedge clk) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start_p0 && !stop_p0) next_state = S_RESET;
            S_RESET: begin
                if (stop_p0)                       next_state = S_IDLE;
                else if (phase_cnt == RESET_LAST)  next_state = S_ARM;
            end
            S_ARM:   next_state = stop_p0 ? S_IDLE : S_RUN;
            S_RUN:   if (stop_p0 || run_timer == 32'd1) next_state = S_DRAIN;
            S_DRAIN: if (phase_cnt == DRAIN_LAST) next_state = S_DONE;
            S_DONE: begin
                if (start_p0 && !stop_p0) next_state = S_RESET;
                else if (clear_p0)        next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Phase counter restarts on every state change; a zero duration leaves the timer parked at 0
    always_ff @(posedge clk) begin
        if (state != next_state) phase_cnt <= 16'd0;
        else                     phase_cnt <= phase_cnt + 16'd1;

        if (state == S_RESET && next_state == S_ARM)
            run_timer <= duration;
        else if (state == S_RUN && run_timer > 32'd1)
            run_timer <= run_timer - 32'd1;
    end

    assign idle_or_done = (state == S_IDLE) || (state == S_DONE);
    assign clr_cnt      = idle_or_done && (clear_p0 || next_state == S_RESET);

    // Record counting stage
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            record_count <= 32'd0;
            lost_count   <= 16'd0;
        end else if (clr_cnt) begin
            record_count <= 32'd0;
            lost_count   <= 16'd0;
        end else if ((state == S_RUN || state == S_DRAIN) && data_rdy) begin
            if (fifo_full) lost_count   <= sat_inc16(lost_count);
            else           record_count <= sat_inc32(record_count);
        end
    end

    assign reset_counter   = (state == S_RESET);
    assign counter_operate = (state == S_ARM) || (state == S_RUN) || (state == S_DRAIN);
    assign capture_operate = (state == S_RUN);
    assign busy            = !idle_or_done;
    assign done            = (state == S_DONE);

endmodule

// File: tb/tb_tagger_sequencer.sv
// Directed bench for tagger_sequencer: run timing, stop/abort, counting and saturation.
module tb_tagger_sequencer;

    localparam logic [7:0] ADDR = 8'h08;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  reg_addr;
    logic [7:0]  reg_data;
    logic        reg_wr;
    logic        data_rdy;
    logic        fifo_full;
    logic        capture_operate;
    logic        counter_operate;
    logic        reset_counter;
    logic        busy;
    logic        done;
    logic [31:0] record_count;
    logic [15:0] lost_count;

    int total = 0;
    int bad   = 0;

    tagger_sequencer #(.ADDR(ADDR), .RESET_CYCLES(4), .DRAIN_CYCLES(8)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .reg_addr        (reg_addr),
        .reg_data        (reg_data),
        .reg_wr          (reg_wr),
        .data_rdy        (data_rdy),
        .fifo_full       (fifo_full),
        .capture_operate (capture_operate),
        .counter_operate (counter_operate),
        .reset_counter   (reset_counter),
        .busy            (busy),
        .done            (done),
        .record_count    (record_count),
        .lost_count      (lost_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        reg_addr = a;
        reg_data = d;
        reg_wr   = 1'b1;
        tick();
        reg_wr   = 1'b0;
    endtask

    task automatic set_duration(input logic [31:0] d);
        wr(ADDR + 8'd1, d[7:0]);
        wr(ADDR + 8'd2, d[15:8]);
        wr(ADDR + 8'd3, d[23:16]);
        wr(ADDR + 8'd4, d[31:24]);
    endtask

    task automatic wait_capture(input string tag);
        int n = 0;
        while (!capture_operate && n < 50) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, capture_operate}, 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic pulse(input logic full);
        data_rdy  = 1'b1;
        fifo_full = full;
        tick();
        data_rdy  = 1'b0;
        fifo_full = 1'b0;
        tick();
    endtask

    initial begin
        int rc_cnt, cap_cnt, cap_first, cap_last, done_first, viol;
        logic arm_op;

        reset_n = 1'b0; reg_addr = 8'd0; reg_data = 8'd0; reg_wr = 1'b0;
        data_rdy = 1'b0; fifo_full = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        chk("rst_cap",  {31'd0, capture_operate}, 32'd0);
        chk("rst_cop",  {31'd0, counter_operate}, 32'd0);
        chk("rst_rc",   {31'd0, reset_counter},   32'd0);
        chk("rst_busy", {31'd0, busy},            32'd0);
        chk("rst_done", {31'd0, done},            32'd0);
        chk("rst_rec",  record_count,             32'd0);
        chk("rst_lost", {16'd0, lost_count},      32'd0);

        // Start written to an unmapped address must do nothing
        wr(ADDR + 8'd5, 8'h01);
        tick(); tick();
        chk("badaddr_busy", {31'd0, busy}, 32'd0);

        // Timed run, duration 100: expect RESET i=1..4, ARM i=5, RUN i=6..105, DRAIN i=106..113, DONE i=114
        set_duration(32'd100);
        wr(ADDR, 8'h01);
        rc_cnt = 0; cap_cnt = 0; cap_first = 0; cap_last = 0; done_first = 0; viol = 0; arm_op = 1'b0;
        for (int i = 1; i <= 130; i++) begin
            tick();
            if (reset_counter) rc_cnt++;
            if (capture_operate) begin
                cap_cnt++;
                if (cap_first == 0) cap_first = i;
                cap_last = i;
            end
            if (i == 5) arm_op = counter_operate && !capture_operate && !reset_counter;
            if (done && done_first == 0) done_first = i;
            if (reset_counter && (counter_operate || capture_operate)) viol++;
            if (capture_operate && !counter_operate) viol++;
        end
        chk("run_rc_len",    rc_cnt,          32'd4);
        chk("run_arm",       {31'd0, arm_op}, 32'd1);
        chk("run_cap_len",   cap_cnt,         32'd100);
        chk("run_cap_first", cap_first,       32'd6);
        chk("run_cap_last",  cap_last,        32'd105);
        chk("run_done_at",   done_first,      32'd114);
        chk("run_invariant", viol,            32'd0);
        chk("run_done_busy", {31'd0, busy},   32'd0);

        // Clear back to IDLE, then 3 pulses that must not count
        wr(ADDR, 8'h04);
        tick();
        chk("clr_done", {31'd0, done}, 32'd0);
        repeat (3) pulse(1'b0);
        chk("idle_rec", record_count, 32'd0);

        // Free run with counting and a stop 500 cycles into RUN
        set_duration(32'd0);
        wr(ADDR, 8'h01);
        wait_capture("free_cap_on");
        for (int k = 0; k < 20; k++) pulse((k % 4) == 0);
        repeat (500 - 40) tick();
        wr(ADDR, 8'h02);
        chk("stop_cap_hold", {31'd0, capture_operate}, 32'd1);
        tick();
        chk("stop_cap_fall", {31'd0, capture_operate}, 32'd0);
        chk("stop_drain_op", {31'd0, counter_operate}, 32'd1);
        repeat (7) tick();
        chk("stop_drain_busy", {31'd0, done}, 32'd0);
        tick();
        chk("stop_done", {31'd0, done}, 32'd1);
        chk("cnt_rec",   record_count,        32'd15);
        chk("cnt_lost",  {16'd0, lost_count}, 32'd5);

        // Lost-count saturation
        wr(ADDR, 8'h04);
        tick();
        chk("clr_lost", {16'd0, lost_count}, 32'd0);
        wr(ADDR, 8'h01);
        wait_capture("sat_cap_on");
        data_rdy = 1'b1; fifo_full = 1'b1;
        repeat (65534) tick();
        chk("sat_lost_fffe", {16'd0, lost_count}, 32'h0000_FFFE);
        repeat (3) tick();
        chk("sat_lost_ffff", {16'd0, lost_count}, 32'h0000_FFFF);
        chk("sat_rec",       record_count,        32'd0);
        data_rdy = 1'b0; fifo_full = 1'b0;
        wr(ADDR, 8'h02);
        wait_done("sat_done");

        // Stop during RESET aborts to IDLE
        wr(ADDR, 8'h01);
        tick();
        chk("abort_rc_on", {31'd0, reset_counter}, 32'd1);
        wr(ADDR, 8'h02);
        tick();
        chk("abort_rc_off", {31'd0, reset_counter}, 32'd0);
        chk("abort_busy",   {31'd0, busy},          32'd0);
        chk("abort_done",   {31'd0, done},          32'd0);

        // Start and stop in one write: stop wins, nothing starts
        wr(ADDR, 8'h03);
        repeat (3) tick();
        chk("prio_busy", {31'd0, busy},          32'd0);
        chk("prio_rc",   {31'd0, reset_counter}, 32'd0);

        // reset_n low mid-RUN drops everything on that edge
        wr(ADDR, 8'h01);
        wait_capture("mid_cap_on");
        repeat (10) tick();
        reset_n = 1'b0;
        tick();
        chk("midrst_cap",  {31'd0, capture_operate}, 32'd0);
        chk("midrst_cop",  {31'd0, counter_operate}, 32'd0);
        chk("midrst_busy", {31'd0, busy},            32'd0);
        reset_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
